// File: rtl/frame_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_mem_pkg
// Purpose  : Tile frame memory geometry and clear-sweep state encoding.
// Revision : 1.0  initial release
// ============================================================================
package frame_mem_pkg;

   localparam int TILE_COLS = 80;
   localparam int TILE_ROWS = 60;
   localparam int DEPTH     = TILE_COLS * TILE_ROWS;
   localparam int AW        = 13;
   localparam int DW        = 24;
   localparam int MAX_WAIT  = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   // Row-major tile index, shared with the display address generator.
   function automatic logic [AW-1:0] tile_addr(input logic [6:0] col, input logic [5:0] row);
      return AW'(row) * AW'(TILE_COLS) + AW'(col);
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_mem_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : frame_mem_rd_pipe
// Purpose  : Two-stage valid/out-of-range shift pipeline registering RAM read data.
// Revision : 1.0  initial release
// ============================================================================
module frame_mem_rd_pipe #(
   parameter int DW = 24
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          acc,
   input  logic          acc_oor,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid
);

   logic [1:0] r_vld;
   logic [1:0] r_oor;

   // Stage 0 tracks the address cycle, stage 1 the RAM data cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld    <= '0;
         r_oor    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         r_vld    <= {r_vld[0], acc};
         r_oor    <= {r_oor[0], acc & acc_oor};
         rd_valid <= r_vld[1];
         if (r_vld[1]) begin
            rd_data <= r_oor[1] ? '0 : mem_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/frame_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frame_mem_arbiter
// Purpose  : Single-port frame memory arbiter: display reads, tile writes, clear sweep.
// Revision : 1.0  initial release
// ============================================================================
module frame_mem_arbiter #(
   parameter int DEPTH    = frame_mem_pkg::DEPTH,
   parameter int AW       = frame_mem_pkg::AW,
   parameter int DW       = frame_mem_pkg::DW,
   parameter int MAX_WAIT = frame_mem_pkg::MAX_WAIT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_gnt,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_gnt,
   input  logic          clr_start,
   input  logic [DW-1:0] clr_color,
   output logic          clr_busy,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wen,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   import frame_mem_pkg::*;

   localparam int            WW          = $clog2(MAX_WAIT + 1);
   localparam logic [AW-1:0] c_depth     = AW'(DEPTH);
   localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
   localparam logic [WW-1:0] c_max_wait  = WW'(MAX_WAIT);

   clr_state_t    r_state;
   logic [AW-1:0] r_clr_addr;
   logic [DW-1:0] r_clr_color;
   logic [WW-1:0] r_wr_wait;

   logic w_wr_urgent;
   logic w_clr_slot;
   logic w_rd_oor;
   logic w_wr_oor;

   // A starved write outranks reads; otherwise reads win and clear takes leftovers.
   assign w_wr_urgent = wr_req && (r_wr_wait == c_max_wait);
   assign wr_gnt      = wr_req && (w_wr_urgent || !rd_req);
   assign rd_gnt      = rd_req && !w_wr_urgent;
   assign w_clr_slot  = (r_state == CLEAR) && !rd_req && !wr_req;
   assign w_rd_oor    = (rd_addr >= c_depth);
   assign w_wr_oor    = (wr_addr >= c_depth);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_wait <= '0;
      end else if (wr_req && !wr_gnt) begin
         if (r_wr_wait != c_max_wait) begin
            r_wr_wait <= r_wr_wait + 1'b1;
         end
      end else begin
         r_wr_wait <= '0;
      end
   end

   // RAM port; mem_addr holds when nobody is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= '0;
         mem_wen   <= 1'b0;
         mem_wdata <= '0;
      end else if (wr_gnt) begin
         mem_addr  <= wr_addr;
         mem_wdata <= wr_data;
         mem_wen   <= !w_wr_oor;
      end else if (rd_gnt) begin
         mem_addr  <= rd_addr;
         mem_wen   <= 1'b0;
      end else if (w_clr_slot) begin
         mem_addr  <= r_clr_addr;
         mem_wdata <= r_clr_color;
         mem_wen   <= 1'b1;
      end else begin
         mem_wen   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_clr_addr  <= '0;
         r_clr_color <= '0;
         clr_busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (clr_start) begin
                  r_state     <= CLEAR;
                  r_clr_addr  <= '0;
                  r_clr_color <= clr_color;
                  clr_busy    <= 1'b1;
               end
            end
            CLEAR: begin
               if (w_clr_slot) begin
                  if (r_clr_addr == c_last_addr) begin
                     r_state    <= IDLE;
                     r_clr_addr <= '0;
                     clr_busy   <= 1'b0;
                  end else begin
                     r_clr_addr <= r_clr_addr + 1'b1;
                  end
               end
            end
            default: begin
               r_state  <= IDLE;
               clr_busy <= 1'b0;
            end
         endcase
      end
   end

   frame_mem_rd_pipe #(
      .DW (DW)
   ) u_rd_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .acc       (rd_gnt),
      .acc_oor   (w_rd_oor),
      .mem_rdata (mem_rdata),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid)
   );

endmodule
`default_nettype wire
